// File: rtl/cond_logic_mc.sv
// rtl/cond_logic_mc.sv - conditional-execution stage of the multicycle ARM control path
module cond_logic_mc #(
  parameter logic [3:0] FLAG_RST    = 4'b0000,
  parameter logic       UNCOND_PASS = 1'b1
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       Branch,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NextPC,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags,
  output logic       CondExQ
);

  // Flag register split into the two independently written halves.
  logic [1:0] nz_q, nz_d;
  logic [1:0] cv_q, cv_d;
  logic       condex_q, condex_d;
  logic       cond_ex;

  logic flag_n, flag_z, flag_c, flag_v;

  assign flag_n = nz_q[1];
  assign flag_z = nz_q[0];
  assign flag_c = cv_q[1];
  assign flag_v = cv_q[0];

  // Condition evaluation against the registered (pre-update) flags.
  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = ~flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = ~flag_v;
      4'b1000: cond_ex = flag_c & ~flag_z;
      4'b1001: cond_ex = ~flag_c | flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = UNCOND_PASS;
    endcase
  end

  // Next-state: each flag half loads only when requested and the condition passes.
  always_comb begin
    nz_d     = nz_q;
    cv_d     = cv_q;
    condex_d = cond_ex;
    if (FlagW[1] && cond_ex) begin
      nz_d = ALUFlags[3:2];
    end
    if (FlagW[0] && cond_ex) begin
      cv_d = ALUFlags[1:0];
    end
  end

  // State registers; reset wins over any simultaneous flag write.
  always_ff @(posedge clk) begin
    if (Reset) begin
      nz_q     <= FLAG_RST[3:2];
      cv_q     <= FLAG_RST[1:0];
      condex_q <= 1'b0;
    end else begin
      nz_q     <= nz_d;
      cv_q     <= cv_d;
      condex_q <= condex_d;
    end
  end

  // Gated write enables; fetch (NextPC) is never condition-gated, and reset
  // suppresses every enable combinationally.
  always_comb begin
    PCWrite  = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    if (!Reset) begin
      PCWrite  = NextPC | (Branch & cond_ex);
      RegWrite = RegW & condex_q;
      MemWrite = MemW & condex_q;
    end
  end

  assign Flags   = {nz_q, cv_q};
  assign CondExQ = condex_q;

endmodule

// File: tb/tb_cond_logic_mc.sv
// tb/tb_cond_logic_mc.sv - self-checking bench for cond_logic_mc
module tb_cond_logic_mc;

  logic       clk;
  logic       Reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       Branch, RegW, MemW, NextPC;
  logic       PCWrite, RegWrite, MemWrite;
  logic [3:0] Flags;
  logic       CondExQ;

  int errors = 0;
  int checks = 0;

  cond_logic_mc dut (
    .clk      (clk),
    .Reset    (Reset),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .Branch   (Branch),
    .RegW     (RegW),
    .MemW     (MemW),
    .NextPC   (NextPC),
    .PCWrite  (PCWrite),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .Flags    (Flags),
    .CondExQ  (CondExQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference condition table written directly from the ARM condition codes.
  function automatic logic pass_of(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  // Behavioural model: architectural flags and the previous cycle's pass bit.
  logic [3:0] m_flags;
  logic       m_cex;
  logic       m_valid = 1'b0;

  // Model update at each rising edge from the inputs held during that cycle.
  always @(posedge clk) begin
    logic p;
    p = pass_of(Cond, m_flags);
    if (Reset) begin
      m_flags = 4'b0000;
      m_cex   = 1'b0;
    end else begin
      if (FlagW[1] && p) m_flags[3:2] = ALUFlags[3:2];
      if (FlagW[0] && p) m_flags[1:0] = ALUFlags[1:0];
      m_cex = p;
    end
    m_valid = 1'b1;
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle once reset has been sampled, outputs vs model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_flags",  Flags,    m_flags);
      chk("m_condexq", {3'b0, CondExQ}, {3'b0, m_cex});
      chk("m_pcwrite", {3'b0, PCWrite},
          {3'b0, !Reset && (NextPC || (Branch && pass_of(Cond, m_flags)))});
      chk("m_regwrite", {3'b0, RegWrite}, {3'b0, !Reset && RegW && m_cex});
      chk("m_memwrite", {3'b0, MemWrite}, {3'b0, !Reset && MemW && m_cex});
    end
  end

  task automatic drive(input logic rst, input logic [3:0] c, input logic [3:0] af,
                       input logic [1:0] fw, input logic br, input logic rw,
                       input logic mw, input logic npc);
    Reset = rst; Cond = c; ALUFlags = af; FlagW = fw;
    Branch = br; RegW = rw; MemW = mw; NextPC = npc;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Load the flag register through an AL instruction with both halves enabled.
  task automatic load_flags(input logic [3:0] f);
    drive(0, 4'b1110, f, 2'b11, 0, 0, 0, 0);
    next_cycle();
  endtask

  logic [3:0] sweep [4];
  logic       ge_exp [4];
  logic       gt_exp [4];
  logic [3:0] hz [4];
  logic       hi_exp [4];
  logic       ls_exp [4];

  initial begin
    sweep  = '{4'b1001, 4'b1000, 4'b0000, 4'b0100};
    ge_exp = '{1'b1, 1'b0, 1'b1, 1'b1};
    gt_exp = '{1'b1, 1'b0, 1'b1, 1'b0};
    hz     = '{4'b0010, 4'b0110, 4'b0000, 4'b0100};
    hi_exp = '{1'b1, 1'b0, 1'b0, 1'b0};
    ls_exp = '{1'b0, 1'b1, 1'b1, 1'b1};

    // 1: reset held two cycles against every enable and a flag write
    drive(1, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 1);
    @(negedge clk);
    chk("rst_pcwrite0", {3'b0, PCWrite}, 4'd0);
    chk("rst_regwrite0", {3'b0, RegWrite}, 4'd0);
    chk("rst_memwrite0", {3'b0, MemWrite}, 4'd0);
    next_cycle();
    @(negedge clk);
    chk("rst_flags", Flags, 4'b0000);
    chk("rst_condexq", {3'b0, CondExQ}, 4'd0);
    chk("rst_pcwrite1", {3'b0, PCWrite}, 4'd0);
    chk("rst_memwrite1", {3'b0, MemWrite}, 4'd0);
    next_cycle();

    // 2: AL write of Z, then writeback
    drive(0, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 0);
    next_cycle();
    drive(0, 4'b1110, 4'b0000, 2'b00, 0, 1, 0, 0);
    @(negedge clk);
    chk("al_flags", Flags, 4'b0100);
    chk("al_regwrite", {3'b0, RegWrite}, 4'd1);
    next_cycle();

    // 3: NE fails with Z=1; flags hold and writeback suppressed
    drive(0, 4'b0001, 4'b1000, 2'b11, 0, 0, 0, 0);
    next_cycle();
    drive(0, 4'b1110, 4'b0000, 2'b00, 0, 1, 0, 0);
    @(negedge clk);
    chk("ne_flags", Flags, 4'b0100);
    chk("ne_condexq", {3'b0, CondExQ}, 4'd0);
    chk("ne_regwrite", {3'b0, RegWrite}, 4'd0);
    next_cycle();

    // 4: branch gating and ungated fetch
    drive(0, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 0);
    @(negedge clk);
    chk("beq_pcwrite", {3'b0, PCWrite}, 4'd1);
    next_cycle();
    drive(0, 4'b0001, 4'b0000, 2'b00, 1, 0, 0, 0);
    @(negedge clk);
    chk("bne_pcwrite", {3'b0, PCWrite}, 4'd0);
    next_cycle();
    drive(0, 4'b0001, 4'b0000, 2'b00, 0, 0, 0, 1);
    @(negedge clk);
    chk("fetch_pcwrite", {3'b0, PCWrite}, 4'd1);
    next_cycle();

    // 5: signed compares and unsigned HI/LS
    for (int i = 0; i < 4; i++) begin
      load_flags(sweep[i]);
      drive(0, 4'b1010, 4'b0000, 2'b00, 1, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("ge_%b", sweep[i]), {3'b0, PCWrite}, {3'b0, ge_exp[i]});
      drive(0, 4'b1100, 4'b0000, 2'b00, 1, 0, 0, 0);
      #1;
      chk($sformatf("gt_%b", sweep[i]), {3'b0, PCWrite}, {3'b0, gt_exp[i]});
      next_cycle();
    end
    for (int i = 0; i < 4; i++) begin
      load_flags(hz[i]);
      drive(0, 4'b1000, 4'b0000, 2'b00, 1, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("hi_%b", hz[i]), {3'b0, PCWrite}, {3'b0, hi_exp[i]});
      drive(0, 4'b1001, 4'b0000, 2'b00, 1, 0, 0, 0);
      #1;
      chk($sformatf("ls_%b", hz[i]), {3'b0, PCWrite}, {3'b0, ls_exp[i]});
      next_cycle();
    end

    // 6: store path under LT, then reset during the store cycle
    load_flags(4'b1000);
    drive(0, 4'b1011, 4'b0000, 2'b00, 0, 0, 0, 0);
    next_cycle();
    drive(0, 4'b1110, 4'b0000, 2'b00, 0, 0, 1, 0);
    @(negedge clk);
    chk("lt_memwrite1", {3'b0, MemWrite}, 4'd1);
    next_cycle();
    load_flags(4'b1001);
    drive(0, 4'b1011, 4'b0000, 2'b00, 0, 0, 0, 0);
    next_cycle();
    drive(0, 4'b1110, 4'b0000, 2'b00, 0, 0, 1, 0);
    @(negedge clk);
    chk("lt_memwrite0", {3'b0, MemWrite}, 4'd0);
    next_cycle();
    load_flags(4'b1000);
    drive(0, 4'b1011, 4'b0000, 2'b00, 0, 0, 0, 0);
    next_cycle();
    drive(1, 4'b1110, 4'b0000, 2'b00, 0, 0, 1, 0);
    @(negedge clk);
    chk("rst_store_memwrite", {3'b0, MemWrite}, 4'd0);
    next_cycle();
    drive(0, 4'b1110, 4'b0000, 2'b00, 0, 0, 1, 0);
    @(negedge clk);
    chk("post_rst_condexq", {3'b0, CondExQ}, 4'd0);
    chk("post_rst_memwrite", {3'b0, MemWrite}, 4'd0);
    chk("post_rst_flags", Flags, 4'b0000);
    next_cycle();

    // Randomized traffic, checked every cycle by the model compare process
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 31) == 0), 4'($urandom), 4'($urandom), 2'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
      next_cycle();
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
